seq_divider: RTL and testbench

Parametrised multi-cycle integer divider that succeeds the 4-bit combinational divider in the ALU datapath.
- Computes quotient and remainder of WIDTH-bit operands with one restoring-division step per clock.
- Supports unsigned and signed (truncating) modes.
- Uses a start/busy/done handshake so the ALU sequencer can issue back-to-back divisions.
- Keeps the existing divide-by-zero contract: Q=0, R=dividend, valid=0.

---
 rtl/seq_divider_if.sv | 25 ++
 rtl/seq_divider.sv | 140 ++++++++++++++
 tb/tb_seq_divider.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bundle for seq_divider.
// The ALU sequencer drives the master side; the divider is the slave.
interface seq_divider_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             valid;

  modport master (
    output start, signed_mode, dividend, divisor,
    input  busy, done, quotient, remainder, valid
  );

  modport slave (
    input  start, signed_mode, dividend, divisor,
    output busy, done, quotient, remainder, valid
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, unsigned or signed (truncating).
// Divide-by-zero returns Q=0, R=dividend, valid=0 after a single extra cycle.
module seq_divider #(
  parameter int unsigned WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  seq_divider_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic [WIDTH-1:0]  dvs_q, dvs_d;
  logic [WIDTH-1:0]  raw_q, raw_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic              div_zero_q, div_zero_d;
  logic [WIDTH-1:0]  quotient_q, quotient_d;
  logic [WIDTH-1:0]  remainder_q, remainder_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;

  logic              a_neg, b_neg;
  logic [WIDTH:0]    rem_shift;
  logic [WIDTH:0]    trial;

  assign a_neg     = bus.signed_mode & bus.dividend[WIDTH-1];
  assign b_neg     = bus.signed_mode & bus.divisor[WIDTH-1];
  // One extra bit so the trial subtraction sign is never lost to overflow.
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, dvs_q};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    raw_d       = raw_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    div_zero_d  = div_zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    valid_d     = valid_q;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          quo_d      = a_neg ? -bus.dividend : bus.dividend;
          dvs_d      = b_neg ? -bus.divisor : bus.divisor;
          raw_d      = bus.dividend;
          rem_d      = '0;
          cnt_d      = '0;
          neg_quo_d  = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          div_zero_d = (bus.divisor == '0);
          state_d    = (bus.divisor == '0) ? StFin : StCalc;
        end
      end

      StCalc: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_shift[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StFin;
        end
      end

      StFin: begin
        if (div_zero_q) begin
          quotient_d  = '0;
          remainder_d = raw_q;
          valid_d     = 1'b0;
        end else begin
          // Most-negative / -1 wraps naturally: magnitude 2^(W-1) stays un-negated.
          quotient_d  = neg_quo_q ? -quo_q : quo_q;
          remainder_d = neg_rem_q ? -rem_q : rem_q;
          valid_d     = 1'b1;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      raw_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      div_zero_q  <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      raw_q       <= raw_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      div_zero_q  <= div_zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = done_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.valid     = valid_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks of seq_divider at WIDTH=4 and WIDTH=8 against an
// arithmetic reference model.
module tb_seq_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(8)) b8 ();
  seq_divider_if #(.WIDTH(4)) b4 ();

  seq_divider #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));
  seq_divider #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero.
  function automatic void model(input int w, input bit sm, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] q,
                                output logic [31:0] r, output logic v);
    longint sa, sb, m;
    m = (longint'(1) << w) - 1;
    if (b == 0) begin
      q = 0; r = a; v = 1'b0;
      return;
    end
    sa = longint'(a);
    sb = longint'(b);
    if (sm && a[w-1]) sa = sa - (longint'(1) << w);
    if (sm && b[w-1]) sb = sb - (longint'(1) << w);
    q = 32'((sa / sb) & m);
    r = 32'((sa % sb) & m);
    v = 1'b1;
  endfunction

  // Called one time unit after a clock edge; returns in the done cycle (edge + 1).
  task automatic op8(input bit sm, input logic [7:0] a, input logic [7:0] b,
                     input bit intrude, input bit chk_width, input string tag);
    logic [31:0] eq, er;
    logic        ev;
    int          lat, busy_n, exp_lat;
    model(8, sm, {24'd0, a}, {24'd0, b}, eq, er, ev);
    exp_lat = (b == 0) ? 1 : 9;
    b8.start = 1'b1; b8.signed_mode = sm; b8.dividend = a; b8.divisor = b;
    @(posedge clk); #1;
    b8.start = 1'b0;
    b8.dividend = 8'($urandom); b8.divisor = 8'($urandom); b8.signed_mode = 1'($urandom);
    lat = 0; busy_n = 0;
    for (int i = 1; i <= 20; i++) begin
      if (b8.busy) busy_n++;
      if (intrude && i == 2) begin
        b8.start = 1'b1; b8.dividend = 8'hFF; b8.divisor = 8'h01; b8.signed_mode = 1'b0;
      end
      if (intrude && i == 3) b8.start = 1'b0;
      @(posedge clk); #1;
      if (b8.done) begin
        lat = i;
        break;
      end
    end
    chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".busy_cycles"}, 64'(busy_n), 64'(exp_lat));
    chk({tag, ".busy_in_done"}, 64'(b8.busy), 64'd0);
    chk({tag, ".quotient"}, 64'(b8.quotient), 64'(eq[7:0]));
    chk({tag, ".remainder"}, 64'(b8.remainder), 64'(er[7:0]));
    chk({tag, ".valid"}, 64'(b8.valid), 64'(ev));
    if (chk_width) begin
      @(posedge clk); #1;
      chk({tag, ".done_width"}, 64'(b8.done), 64'd0);
      chk({tag, ".held_q"}, 64'(b8.quotient), 64'(eq[7:0]));
    end
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input bit sm, input string tag);
    logic [31:0] eq, er;
    logic        ev;
    int          lat, exp_lat;
    model(4, sm, {28'd0, a}, {28'd0, b}, eq, er, ev);
    exp_lat = (b == 0) ? 1 : 5;
    b4.start = 1'b1; b4.signed_mode = sm; b4.dividend = a; b4.divisor = b;
    @(posedge clk); #1;
    b4.start = 1'b0; b4.dividend = 4'($urandom); b4.divisor = 4'($urandom);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (b4.done) begin
        lat = i;
        break;
      end
    end
    chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".quotient"}, 64'(b4.quotient), 64'(eq[3:0]));
    chk({tag, ".remainder"}, 64'(b4.remainder), 64'(er[3:0]));
    chk({tag, ".valid"}, 64'(b4.valid), 64'(ev));
  endtask

  initial begin
    int done_n;
    logic [7:0] ra, rb;
    logic [3:0] ta, tb;
    b8.start = 1'b0; b8.signed_mode = 1'b0; b8.dividend = '0; b8.divisor = '0;
    b4.start = 1'b0; b4.signed_mode = 1'b0; b4.dividend = '0; b4.divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy8", 64'(b8.busy), 64'd0);
    chk("rst.done8", 64'(b8.done), 64'd0);
    chk("rst.q8", 64'(b8.quotient), 64'd0);
    chk("rst.r8", 64'(b8.remainder), 64'd0);
    chk("rst.v8", 64'(b8.valid), 64'd0);
    chk("rst.busy4", 64'(b4.busy), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    op4(4'd0, 4'd1, 1'b0, "w4_0_1");
    op4(4'd1, 4'd1, 1'b0, "w4_1_1");
    op4(4'd4, 4'd2, 1'b0, "w4_4_2");
    op4(4'd7, 4'd4, 1'b0, "w4_7_4");
    op4(4'd10, 4'd3, 1'b0, "w4_10_3");

    op8(1'b0, 8'd200, 8'd7, 1'b0, 1'b1, "u200_7");
    op8(1'b0, 8'd9, 8'd0, 1'b0, 1'b1, "u9_0");
    op8(1'b1, 8'hF9, 8'h02, 1'b0, 1'b0, "s_m7_2");
    op8(1'b1, 8'h07, 8'hFE, 1'b0, 1'b0, "s_7_m2");
    op8(1'b1, 8'h80, 8'hFF, 1'b0, 1'b1, "s_m128_m1");
    op8(1'b1, 8'hF9, 8'h00, 1'b0, 1'b0, "s_m7_0");
    op8(1'b0, 8'd123, 8'd5, 1'b1, 1'b1, "intrude");
    // Back-to-back: the second start is raised in the done cycle of the first.
    op8(1'b0, 8'd100, 8'd7, 1'b0, 1'b0, "b2b_first");
    op8(1'b0, 8'd100, 8'd10, 1'b0, 1'b1, "b2b_second");

    // Reset during the 4th CALC cycle, with a start on the reset edge.
    b8.start = 1'b1; b8.signed_mode = 1'b0; b8.dividend = 8'd200; b8.divisor = 8'd7;
    @(posedge clk); #1;
    b8.start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    b8.start = 1'b1; b8.dividend = 8'd50; b8.divisor = 8'd6;
    @(posedge clk); #1;
    chk("midrst.busy", 64'(b8.busy), 64'd0);
    chk("midrst.done", 64'(b8.done), 64'd0);
    chk("midrst.q", 64'(b8.quotient), 64'd0);
    chk("midrst.r", 64'(b8.remainder), 64'd0);
    chk("midrst.v", 64'(b8.valid), 64'd0);
    rst = 1'b0;
    b8.start = 1'b0;
    done_n = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (b8.done || b8.busy) done_n++;
    end
    chk("midrst.no_activity", 64'(done_n), 64'd0);
    op8(1'b0, 8'd50, 8'd6, 1'b0, 1'b1, "after_rst");

    for (int n = 0; n < 40; n++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      op8(1'($urandom), ra, rb, 1'($urandom_range(0, 3) == 0), 1'b0, "rand8");
    end
    for (int n = 0; n < 15; n++) begin
      ta = 4'($urandom);
      tb = 4'($urandom);
      op4(ta, tb, 1'($urandom), "rand4");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
